// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - parametrised universal shift/rotate/load register
//
// Holds a WIDTH-bit word and, on each rising edge, performs hold, parallel
// load, logical shift left/right, rotate left/right, arithmetic shift right
// or clear as selected by mode. Qbar is a registered complement kept in the
// same assignment as Q; SO is the registered last bit shifted/rotated out.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset (Q=RESET_VAL, SO=0)
//   en    in   1      clock enable; 0 holds all state
//   mode  in   3      000 hold, 001 load, 010 shl, 011 shr,
//                     100 rol, 101 ror, 110 asr, 111 clear
//   D     in   WIDTH  parallel load data
//   SIL   in   1      serial in to bit 0 on shift-left
//   SIR   in   1      serial in to bit WIDTH-1 on shift-right
//   Q     out  WIDTH  register contents
//   Qbar  out  WIDTH  registered ~Q
//   SO    out  1      registered shift-out bit
//   zero  out  1      combinational Q == 0

module shift_reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             SO,
    output logic             zero
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Next word computed once so Q and Qbar are always written from the
    // same value and can never disagree.
    logic [WIDTH-1:0] q_next;
    logic             so_next;

    always_comb begin
        q_next  = Q;
        so_next = SO;
        case (mode)
            MODE_HOLD: begin
                q_next  = Q;
                so_next = SO;
            end
            MODE_LOAD: q_next = D;
            MODE_SHL: begin
                q_next  = {Q[WIDTH-2:0], SIL};
                so_next = Q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {SIR, Q[WIDTH-1:1]};
                so_next = Q[0];
            end
            MODE_ROL: begin
                q_next  = {Q[WIDTH-2:0], Q[WIDTH-1]};
                so_next = Q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {Q[0], Q[WIDTH-1:1]};
                so_next = Q[0];
            end
            MODE_ASR: begin
                // Sign bit replicates; SIR deliberately not used here.
                q_next  = {Q[WIDTH-1], Q[WIDTH-1:1]};
                so_next = Q[0];
            end
            MODE_CLR: begin
                q_next  = {WIDTH{1'b0}};
                so_next = 1'b0;
            end
            default: begin
                q_next  = Q;
                so_next = SO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q    <= RESET_VAL;
            Qbar <= ~RESET_VAL;
            SO   <= 1'b0;
        end else if (en) begin
            Q    <= q_next;
            Qbar <= ~q_next;
            SO   <= so_next;
        end
    end

    assign zero = (Q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - scoreboard bench for shift_reg_univ

module tb_shift_reg_univ;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] D;
    logic       SIL;
    logic       SIR;
    logic [7:0] Q;
    logic [7:0] Qbar;
    logic       SO;
    logic       zero;

    shift_reg_univ #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .D    (D),
        .SIL  (SIL),
        .SIR  (SIR),
        .Q    (Q),
        .Qbar (Qbar),
        .SO   (SO),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       so;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
    localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

    // Drive one edge's inputs on the falling edge and queue what the
    // register must hold after the following rising edge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic sil, input logic sir,
                        input logic [7:0] exp_q, input logic exp_so,
                        input string name);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = m;
        D    = d;
        SIL  = sil;
        SIR  = sir;
        x.q    = exp_q;
        x.so   = exp_so;
        x.name = name;
        sb.push_back(x);
    endtask

    // Monitor: every edge with a pending expectation is checked 1 time unit
    // after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (Q !== e.q) begin
                errors++;
                $display("FAIL %s Q: got %h expected %h", e.name, Q, e.q);
            end
            checks++;
            if (Qbar !== ~e.q) begin
                errors++;
                $display("FAIL %s Qbar: got %h expected %h", e.name, Qbar, ~e.q);
            end
            checks++;
            if (SO !== e.so) begin
                errors++;
                $display("FAIL %s SO: got %b expected %b", e.name, SO, e.so);
            end
            checks++;
            if (zero !== (e.q == 8'h00)) begin
                errors++;
                $display("FAIL %s zero: got %b expected %b", e.name, zero, (e.q == 8'h00));
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b0; en = 1'b0; mode = HOLD; D = 8'h00; SIL = 1'b0; SIR = 1'b0;

        // reset overrides en/mode/D
        step(1, 1, LOAD, 8'hFF, 0, 0, 8'hA5, 0, "reset");
        // load then enable-gated hold
        step(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 0, "load_3c");
        for (int i = 0; i < 3; i++)
            step(0, 0, LOAD, 8'h00, 0, 0, 8'h3C, 0, "en_low_hold");
        // shifts
        step(0, 1, LOAD, 8'h81, 0, 0, 8'h81, 0, "load_81");
        step(0, 1, SHL,  8'h00, 0, 0, 8'h02, 1, "shl_sil0");
        step(0, 1, SHR,  8'h00, 0, 1, 8'h81, 0, "shr_sir1");
        step(0, 1, ASR,  8'h00, 0, 0, 8'hC0, 1, "asr_neg");
        // ASR must ignore SIR
        step(0, 1, LOAD, 8'h01, 0, 1, 8'h01, 1, "load_01");
        step(0, 1, ASR,  8'h00, 0, 1, 8'h00, 1, "asr_sir_ignored");
        // rotate wrap
        step(0, 1, LOAD, 8'h01, 0, 0, 8'h01, 1, "load_01b");
        step(0, 1, ROR,  8'h00, 0, 0, 8'h80, 1, "ror_wrap");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h01, 1, "rol_1");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h02, 0, "rol_2");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h04, 0, "rol_3");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h08, 0, "rol_4");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h10, 0, "rol_5");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h20, 0, "rol_6");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h40, 0, "rol_7");
        step(0, 1, ROL,  8'h00, 0, 0, 8'h80, 0, "rol_8");
        // hold mode ignores serial inputs and D
        step(0, 1, HOLD, 8'hFF, 1, 1, 8'h80, 0, "hold_mode");
        // clear / zero
        step(0, 1, LOAD, 8'hF0, 0, 0, 8'hF0, 0, "load_f0");
        step(0, 1, CLR,  8'h00, 0, 0, 8'h00, 0, "clear");
        step(0, 1, SHL,  8'h00, 1, 0, 8'h01, 0, "shl_sil1");
        // SHR must ignore SIL
        step(0, 1, SHR,  8'h00, 1, 0, 8'h00, 1, "shr_sil_ignored");
        // mid-sequence reset
        step(0, 1, SHL,  8'h00, 1, 0, 8'h01, 0, "shl_seq1");
        step(0, 1, SHL,  8'h00, 1, 0, 8'h03, 0, "shl_seq2");
        step(1, 1, SHL,  8'h00, 1, 0, 8'hA5, 0, "shl_seq_reset");
        step(0, 1, SHL,  8'h00, 1, 0, 8'h4B, 1, "shl_after_reset");
        // enable low blocks clear; reset still wins with en low
        step(0, 0, CLR,  8'h00, 0, 0, 8'h4B, 1, "en_low_clr");
        step(1, 0, CLR,  8'h00, 0, 0, 8'hA5, 0, "reset_en_low");

        @(negedge clk);
        rst = 1'b0; en = 1'b0; mode = HOLD;

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
